// File: rtl/updown_sweep_pkg.sv
// Shared types and default sizing for the triangular sweep sequencer.
package updown_sweep_pkg;

    localparam int WIDTH_DEF     = 4;
    localparam int PAUSE_CYC_DEF = 2;
    localparam int SWP_W_DEF     = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } sweep_state_e;

    // Dwell counter width able to hold 0..pause, never narrower than one bit.
    function automatic int dwell_width(input int pause);
        return (pause < 1) ? 1 : $clog2(pause + 1);
    endfunction

endpackage

// File: rtl/updown_core.sv
// Loadable up/down counter; load wins over enable.
module updown_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    // Counter register: reset, load, step or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {WIDTH{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequences triangular lo..hi sweeps on the up/down core with dwell at each bound.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int PAUSE_CYC = PAUSE_CYC_DEF,
    parameter int SWP_W     = SWP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [SWP_W-1:0] sweeps,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int DW_W = dwell_width(PAUSE_CYC);

    sweep_state_e     state_r;
    logic [WIDTH-1:0] lo_r, hi_r;
    logic [SWP_W-1:0] sweeps_r, sweep_cnt_r, sweep_next_s;
    logic [DW_W-1:0]  dwell_r;
    logic             load_s, en_s, up_s, dwell_hit_s;
    logic             arrive_hi_s, arrive_lo_s, sweep_done_s;
    logic [WIDTH-1:0] count_inc_s, count_dec_s;

    updown_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (lo),
        .en       (en_s),
        .up       (up_s),
        .count    (count)
    );

    // Core steering: the edge that leaves a hold also moves the count, so each bound shows 1+PAUSE_CYC cycles.
    always_comb begin
        load_s       = 1'b0;
        en_s         = 1'b0;
        up_s         = 1'b1;
        dwell_hit_s  = (dwell_r == DW_W'(PAUSE_CYC));
        count_inc_s  = count + WIDTH'(1);
        count_dec_s  = count - WIDTH'(1);
        sweep_next_s = sweep_cnt_r + SWP_W'(1);
        sweep_done_s = (sweeps_r != {SWP_W{1'b0}}) && (sweep_next_s == sweeps_r);
        case (state_r)
            IDLE: begin
                if (start && (lo < hi)) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            UP: begin
                en_s = !abort;
                up_s = 1'b1;
            end
            HOLD_HI: begin
                en_s = !abort && dwell_hit_s;
                up_s = 1'b0;
            end
            DOWN: begin
                en_s = !abort;
                up_s = 1'b0;
            end
            HOLD_LO: begin
                en_s = !abort && dwell_hit_s;
                up_s = 1'b1;
            end
            default: begin
                en_s = 1'b0;
                up_s = 1'b1;
            end
        endcase
        arrive_hi_s = en_s && up_s && (count_inc_s == hi_r);
        arrive_lo_s = en_s && !up_s && (count_dec_s == lo_r);
    end

    // Sweep FSM with registered status outputs; abort only matters outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            dir         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            lo_r        <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            sweeps_r    <= {SWP_W{1'b0}};
            sweep_cnt_r <= {SWP_W{1'b0}};
            dwell_r     <= {DW_W{1'b0}};
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && (state_r != IDLE)) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                dir     <= 1'b1;
                dwell_r <= {DW_W{1'b0}};
            end else if (arrive_lo_s) begin
                sweep_cnt_r <= sweep_next_s;
                dwell_r     <= {DW_W{1'b0}};
                dir         <= 1'b1;
                if (sweep_done_s) begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state_r <= HOLD_LO;
                end
            end else if (arrive_hi_s) begin
                state_r <= HOLD_HI;
                dir     <= 1'b0;
                dwell_r <= {DW_W{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && (lo < hi)) begin
                            lo_r        <= lo;
                            hi_r        <= hi;
                            sweeps_r    <= sweeps;
                            sweep_cnt_r <= {SWP_W{1'b0}};
                            dwell_r     <= {DW_W{1'b0}};
                            dir         <= 1'b1;
                            busy        <= 1'b1;
                            state_r     <= UP;
                        end else if (start) begin
                            err <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    HOLD_HI: begin
                        if (dwell_hit_s) begin
                            state_r <= DOWN;
                        end else begin
                            dwell_r <= dwell_r + DW_W'(1);
                        end
                    end
                    HOLD_LO: begin
                        if (dwell_hit_s) begin
                            state_r <= UP;
                        end else begin
                            dwell_r <= dwell_r + DW_W'(1);
                        end
                    end
                    UP, DOWN: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
